axil_master: RTL
================

// Module: axil_master
// PURPOSE
//  AXI4-Lite initiator that turns single read/write commands into AW/W/B or AR/R transactions.
//  Drives the register-file slave (and any AXI4-Lite slave) from a local cmd/rsp valid-ready pair.
//  One transaction outstanding at a time; response code and read data are returned on the rsp port.
// PARAMETERS
//  ADDR_W          32   address width (cmd_addr, awaddr, araddr)
//  DATA_W          32   data width (cmd_wdata, wdata, rdata, rsp_rdata)
//  TIMEOUT_CYCLES  256  response wait limit; used only with AXIL_MASTER_TIMEOUT_EN
// PORTS
//  clk          in   1       clock; all logic on posedge
//  reset        in   1       synchronous, active-high reset
//  cmd_valid    in   1       command present
//  cmd_ready    out  1       command accepted when cmd_valid&&cmd_ready
//  cmd_write    in   1       1=write, 0=read
//  cmd_addr     in   ADDR_W  byte address, passed unmodified
//  cmd_wdata    in   DATA_W  write data (ignored for reads)
//  rsp_valid    out  1       response present
//  rsp_ready    in   1       response consumed
//  rsp_write    out  1       echo of cmd_write
//  rsp_resp     out  2       BRESP/RRESP, or SLVERR on timeout
//  rsp_rdata    out  DATA_W  RDATA for reads, 0 for writes
//  rsp_timeout  out  1       1=slave never responded (tied 0 without macro)
//  awvalid/awaddr/awready, wvalid/wdata/wready, bvalid/bresp/bready,
//  arvalid/araddr/arready, rvalid/rdata/rresp/rready: AXI4-Lite master side, std directions
// BEHAVIOUR
//  Reset: all valid/ready outputs 0; cmd_ready 0; rsp_* 0; addr/data regs 0; FSM IDLE.
//  FSM: IDLE -> WR_REQ -> WR_RESP -> RSP -> IDLE | IDLE -> RD_REQ -> RD_RESP -> RSP -> IDLE.
//  - IDLE: cmd_ready=1; on accept, latch cmd fields; awvalid+wvalid (write) or arvalid (read) high next cycle.
//  - WR_REQ: aw_done/w_done flags; each valid held until its own ready is sampled high, then cleared
//    the next cycle. Both handshakes may occur in the same or different cycles; leave when both are done.
//  - WR_RESP: bready=1; on bvalid&&bready, capture bresp and enter RSP.
//  - RD_REQ: arvalid held until arready. RD_RESP: rready=1; on rvalid, capture rdata/rresp and enter RSP.
//  - RSP: rsp_valid=1, all rsp_* stable until rsp_ready; then IDLE. cmd_ready=0 in every non-IDLE state.
//  Min latency (slave readies same cycle): cmd accept t0, AW/W t1, B t2, rsp_valid t3.
//  bready/rready are low outside *_RESP; stray bvalid/rvalid in other states is not consumed.
//  AXI rule: a valid is never dropped before its handshake; payload is stable while valid.
//  Reset mid-transaction: abort immediately; the slave shares the same reset.
// CONFIGURATION
//  AXIL_MASTER_TIMEOUT_EN defined: cycle counter runs in WR_RESP/RD_RESP. On reaching TIMEOUT_CYCLES:
//   rsp_valid with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0; FSM then enters DRAIN (bready/rready=1,
//   cmd_ready=0) until the late B/R is absorbed and discarded, then IDLE.
//  Undefined: no counter, no DRAIN; waits forever; rsp_timeout=0.
// STRUCTURE
//  Package axil_pkg: RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
//   FSM state typedef (IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP, DRAIN).
//  Sub-module axil_timeout_ctr (clear/enable/expired), instantiated only under the macro.
// TESTING (bench pairs axil_master with the register-file slave axi4)
//  1 write addr 0x10 data 0xDEADBEEF -> one AW+W, rsp_write=1, rsp_resp=00; slave reg[4]=0xDEADBEEF.
//  2 read addr 0x10 after test 1 -> rsp_rdata=0xDEADBEEF, rsp_resp=00, rsp_write=0.
//  3 stub slave: awready at +1, wready at +4 -> awvalid low after AW handshake, wvalid held to +4, one rsp.
//  4 rsp_ready low for 5 cycles -> rsp_valid/rsp_rdata stable, cmd_ready=0, no new AXI traffic.
//  5 reset asserted in WR_RESP -> next cycle all valids/bready/rsp_valid=0; cmd_ready=1 after release.
//  6 macro on, TIMEOUT_CYCLES=16, bvalid withheld -> rsp_timeout=1, resp=10 16 cycles into WR_RESP;
//    later bvalid absorbed in DRAIN, no second rsp_valid.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response codes and the initiator FSM state encoding.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP,
        DRAIN
    } state_t;

endpackage

// File: rtl/axil_timeout_ctr.sv
// Response-wait counter: counts enabled cycles, restarts on clear, and flags
// expiry on the TIMEOUT_CYCLES-th enabled cycle.
module axil_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && !clear && (count_q == LAST);

endmodule

// File: rtl/axil_master.sv
// AXI4-Lite initiator: one cmd/rsp transaction at a time over AW/W/B or AR/R.
// Optional response timeout with post-timeout drain: define AXIL_MASTER_TIMEOUT_EN.
module axil_master
    import axil_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [1:0]        rsp_resp,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic              awvalid,
    output logic [ADDR_W-1:0] awaddr,
    input  logic              awready,
    output logic              wvalid,
    output logic [DATA_W-1:0] wdata,
    input  logic              wready,
    input  logic              bvalid,
    input  logic [1:0]        bresp,
    output logic              bready,
    output logic              arvalid,
    output logic [ADDR_W-1:0] araddr,
    input  logic              arready,
    input  logic              rvalid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    output logic              rready
);

    state_t            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              arvalid_q, arvalid_d;
    logic              bready_q, bready_d;
    logic              rready_q, rready_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_write_q, rsp_write_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
    assign aw_hs = awvalid_q && awready;
    assign w_hs  = wvalid_q && wready;
    assign ar_hs = arvalid_q && arready;
    assign b_hs  = bvalid && bready_q;
    assign r_hs  = rvalid && rready_q;

`ifdef AXIL_MASTER_TIMEOUT_EN
    logic wait_resp;
    logic timeout_hit;
    assign wait_resp = (state_q == WR_RESP) || (state_q == RD_RESP);

    axil_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (!wait_resp),
        .enable (wait_resp),
        .expired(timeout_hit)
    );
`else
    // Without the timeout feature the slave is waited on indefinitely.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        arvalid_d     = arvalid_q;
        bready_d      = bready_q;
        rready_d      = rready_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_write_d   = rsp_write_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    if (cmd_write) begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_REQ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                // AW and W complete independently; a finished channel stays idle.
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    state_d       = RSP;
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_write_d   = 1'b1;
                    rsp_resp_d    = bresp;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b0;
                end
`ifdef AXIL_MASTER_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d       = DRAIN;
                    rsp_valid_d   = 1'b1;
                    rsp_write_d   = 1'b1;
                    rsp_resp_d    = RESP_SLVERR;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                end
`endif
            end
            RD_REQ: begin
                if (ar_hs) begin
                    state_d   = RD_RESP;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RD_RESP: begin
                if (r_hs) begin
                    state_d       = RSP;
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_write_d   = 1'b0;
                    rsp_resp_d    = rresp;
                    rsp_rdata_d   = rdata;
                    rsp_timeout_d = 1'b0;
                end
`ifdef AXIL_MASTER_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d       = DRAIN;
                    rsp_valid_d   = 1'b1;
                    rsp_write_d   = 1'b0;
                    rsp_resp_d    = RESP_SLVERR;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                end
`endif
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
`ifdef AXIL_MASTER_TIMEOUT_EN
            DRAIN: begin
                // Stay until the timeout response is taken and the late B/R is swallowed.
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
                if (b_hs) begin
                    bready_d = 1'b0;
                end
                if (r_hs) begin
                    rready_d = 1'b0;
                end
                if (!rsp_valid_d && !bready_d && !rready_d) begin
                    state_d     = IDLE;
                    cmd_ready_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_write_q   <= 1'b0;
            rsp_resp_q    <= 2'b00;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            arvalid_q     <= arvalid_d;
            bready_q      <= bready_d;
            rready_q      <= rready_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_write_q   <= rsp_write_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign awvalid     = awvalid_q;
    assign awaddr      = addr_q;
    assign wvalid      = wvalid_q;
    assign wdata       = wdata_q;
    assign bready      = bready_q;
    assign arvalid     = arvalid_q;
    assign araddr      = addr_q;
    assign rready      = rready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_write   = rsp_write_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule
